frame_update_arbiter: RTL and testbench

- Arbitrates two requesters (player-1 and player-2 input logic) that share the single player_address register driving the renderer.
- Commits updates only inside a fixed commit window that opens on each vertical sync pulse, so a frame never shows a mid-scan sprite change.
- Uses round-robin arbitration with a req/grant handshake.
- Runs in the 25 MHz pixel clock domain, between the game input logic and the renderer.

---
 rtl/frame_update_arbiter_if.sv | 37 +++
 rtl/frame_update_arbiter.sv | 144 ++++++++++++++
 tb/tb_frame_update_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/frame_update_arbiter_if.sv
// Bundle between the two requesters, the timing generator's vsync and the renderer.
// FRAME_UPDATE_DROP_CNT_EN adds the drop_count return signal.
interface frame_update_arbiter_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              vsync;
  logic [1:0]        req;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] player_address;
  logic              window_open;
  logic [7:0]        frame_count;
`ifdef FRAME_UPDATE_DROP_CNT_EN
  logic [7:0]        drop_count;

  modport master (
    output vsync, req, req_addr0, req_addr1,
    input  grant, player_address, window_open, frame_count, drop_count
  );

  modport slave (
    input  vsync, req, req_addr0, req_addr1,
    output grant, player_address, window_open, frame_count, drop_count
  );
`else
  modport master (
    output vsync, req, req_addr0, req_addr1,
    input  grant, player_address, window_open, frame_count
  );

  modport slave (
    input  vsync, req, req_addr0, req_addr1,
    output grant, player_address, window_open, frame_count
  );
`endif
endinterface

// File: rtl/frame_update_arbiter.sv
// Round-robin arbiter committing player_address updates only inside the post-vsync window.
// Optional macro FRAME_UPDATE_DROP_CNT_EN adds a saturating count of requests left unserved at close.
module frame_update_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned WINDOW = 1600,
  parameter int unsigned CNT_W  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  frame_update_arbiter_if.slave bus
);

  typedef enum logic {
    S_WAIT_FRAME = 1'b0,
    S_WINDOW     = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

  state_t            r_state, w_state_nxt;
  logic              r_vsync_prev;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [1:0]        r_served, w_served_nxt;
  logic              r_rr_ptr, w_rr_ptr_nxt;
  logic [1:0]        r_grant, w_grant_nxt;
  logic [ADDR_W-1:0] r_player_address, w_player_address_nxt;
  logic              r_window_open, w_window_open_nxt;
  logic [7:0]        r_frame_count, w_frame_count_nxt;

  logic              w_vsync_fall;
  logic [1:0]        w_eligible;
  logic              w_winner;
  logic [1:0]        w_win_onehot;
  logic              w_do_grant;
  logic              w_last;

  assign w_vsync_fall = r_vsync_prev & ~bus.vsync;
  assign w_eligible   = bus.req & ~r_served;
  assign w_winner     = w_eligible[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;
  assign w_win_onehot = w_winner ? 2'b10 : 2'b01;
  // The cycle a grant is visible is a bubble, so the requester can drop req before re-arbitration.
  assign w_do_grant   = (r_state == S_WINDOW) && (w_eligible != 2'b00) && (r_grant == 2'b00);
  assign w_last       = (r_cnt == CNT_LAST);

`ifdef FRAME_UPDATE_DROP_CNT_EN
  logic [7:0] r_drop_count, w_drop_count_nxt;
  logic [1:0] w_dropped;
  logic [8:0] w_drop_sum;

  // A request granted on the closing edge is served, not dropped.
  assign w_dropped  = w_eligible & ~(w_do_grant ? w_win_onehot : 2'b00);
  assign w_drop_sum = 9'(r_drop_count) + 9'(w_dropped[0]) + 9'(w_dropped[1]);
`endif

  // Next-state and registered-output decode.
  always_comb begin
    w_state_nxt          = r_state;
    w_cnt_nxt            = r_cnt;
    w_served_nxt         = r_served;
    w_rr_ptr_nxt         = r_rr_ptr;
    w_grant_nxt          = 2'b00;
    w_player_address_nxt = r_player_address;
    w_window_open_nxt    = r_window_open;
    w_frame_count_nxt    = r_frame_count;
`ifdef FRAME_UPDATE_DROP_CNT_EN
    w_drop_count_nxt     = r_drop_count;
`endif

    case (r_state)
      S_WAIT_FRAME: begin
        if (w_vsync_fall) begin
          w_state_nxt       = S_WINDOW;
          w_cnt_nxt         = '0;
          w_served_nxt      = 2'b00;
          w_window_open_nxt = 1'b1;
        end
      end

      S_WINDOW: begin
        if (w_do_grant) begin
          w_grant_nxt          = w_win_onehot;
          w_player_address_nxt = w_winner ? bus.req_addr1 : bus.req_addr0;
          w_served_nxt         = r_served | w_win_onehot;
          w_rr_ptr_nxt         = ~w_winner;
        end

        if (w_last) begin
          w_state_nxt       = S_WAIT_FRAME;
          w_window_open_nxt = 1'b0;
          w_frame_count_nxt = r_frame_count + 8'd1;
`ifdef FRAME_UPDATE_DROP_CNT_EN
          w_drop_count_nxt  = (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
`endif
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: w_state_nxt = S_WAIT_FRAME;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= S_WAIT_FRAME;
      r_vsync_prev     <= 1'b1;
      r_cnt            <= '0;
      r_served         <= 2'b00;
      r_rr_ptr         <= 1'b0;
      r_grant          <= 2'b00;
      r_player_address <= '0;
      r_window_open    <= 1'b0;
      r_frame_count    <= 8'd0;
    end else begin
      r_state          <= w_state_nxt;
      r_vsync_prev     <= bus.vsync;
      r_cnt            <= w_cnt_nxt;
      r_served         <= w_served_nxt;
      r_rr_ptr         <= w_rr_ptr_nxt;
      r_grant          <= w_grant_nxt;
      r_player_address <= w_player_address_nxt;
      r_window_open    <= w_window_open_nxt;
      r_frame_count    <= w_frame_count_nxt;
    end
  end

`ifdef FRAME_UPDATE_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop_count <= 8'd0;
    end else begin
      r_drop_count <= w_drop_count_nxt;
    end
  end

  assign bus.drop_count = r_drop_count;
`endif

  assign bus.grant          = r_grant;
  assign bus.player_address = r_player_address;
  assign bus.window_open    = r_window_open;
  assign bus.frame_count    = r_frame_count;

endmodule

// File: tb/tb_frame_update_arbiter.sv
// Scoreboard bench for frame_update_arbiter: stimulus queues expected grants, a monitor pops them.
// A short WINDOW keeps 256-frame wrap testing cheap.
module tb_frame_update_arbiter;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned WIN    = 40;
  localparam int unsigned CNT_W  = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  frame_update_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  frame_update_arbiter #(
    .ADDR_W (ADDR_W),
    .WINDOW (WIN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [1:0]        grant;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_val);
    n_checks++;
    if (act !== req_val) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req_val);
    end
  endtask

  task automatic expect_grant(input logic [1:0] g, input logic [ADDR_W-1:0] a);
    exp_t e;
    e.grant = g;
    e.addr  = a;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Single-cycle active-low vsync pulse; returns just after the detecting edge.
  task automatic vfall();
    bus.vsync = 1'b0;
    step(1);
    bus.vsync = 1'b1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.grant !== 2'b00) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_grant: got grant=%b addr=%h, required no grant", bus.grant, bus.player_address);
        end else begin
          e = exp_q.pop_front();
          chk("grant", 32'(bus.grant), 32'(e.grant));
          chk("grant_addr", 32'(bus.player_address), 32'(e.addr));
        end
      end
    end
  endtask

  task automatic run();
    bus.vsync     = 1'b1;
    bus.req       = 2'b00;
    bus.req_addr0 = '0;
    bus.req_addr1 = '0;

    // Reset, then idle with a request but no vsync edge.
    rst = 1'b0;
    step(5);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_addr", 32'(bus.player_address), 32'd0);
    chk("rst_window_open", 32'(bus.window_open), 32'd0);
    chk("rst_frame_count", 32'(bus.frame_count), 32'd0);
`ifdef FRAME_UPDATE_DROP_CNT_EN
    chk("rst_drop_count", 32'(bus.drop_count), 32'd0);
`endif
    rst = 1'b1;
    bus.req = 2'b01; bus.req_addr0 = 4'h7;
    step(100);
    chk("idle_addr", 32'(bus.player_address), 32'd0);
    chk("idle_window_open", 32'(bus.window_open), 32'd0);
    bus.req = 2'b00;
    step(2);

    // Single request held for the whole window; a mid-window vsync edge must not restart it.
    bus.req = 2'b01; bus.req_addr0 = 4'h5;
    expect_grant(2'b01, 4'h5);
    vfall();
    chk("single_window_open", 32'(bus.window_open), 32'd1);
    step(1);
    chk("single_addr", 32'(bus.player_address), 32'h5);
    step(9);
    vfall();
    step(28);
    chk("window_last_cycle_open", 32'(bus.window_open), 32'd1);
    step(1);
    chk("window_closed", 32'(bus.window_open), 32'd0);
    chk("frame_count_1", 32'(bus.frame_count), 32'd1);
    bus.req = 2'b00;
    step(5);

    // Single request from player 2 returns rr_ptr to 0.
    bus.req = 2'b10; bus.req_addr1 = 4'h6;
    expect_grant(2'b10, 4'h6);
    vfall();
    step(WIN + 1);
    bus.req = 2'b00;
    chk("frame_count_2", 32'(bus.frame_count), 32'd2);
    step(5);

    // Contention with rr_ptr=0: player 1, bubble, player 2.
    bus.req = 2'b11; bus.req_addr0 = 4'h3; bus.req_addr1 = 4'h9;
    expect_grant(2'b01, 4'h3);
    expect_grant(2'b10, 4'h9);
    vfall();
    step(1);
    chk("cont_first_addr", 32'(bus.player_address), 32'h3);
    bus.req[0] = 1'b0;
    step(1);
    chk("cont_bubble", 32'(bus.grant), 32'd0);
    step(1);
    bus.req[1] = 1'b0;
    step(WIN - 3);
    chk("cont_final_addr", 32'(bus.player_address), 32'h9);
    chk("frame_count_3", 32'(bus.frame_count), 32'd3);
    step(5);

    // Last winner was player 2, so player 1 wins first again; then reset mid-window.
    bus.req = 2'b11; bus.req_addr0 = 4'h4; bus.req_addr1 = 4'h9;
    expect_grant(2'b01, 4'h4);
    expect_grant(2'b10, 4'h9);
    vfall();
    step(1);
    bus.req[0] = 1'b0;
    step(2);
    bus.req[1] = 1'b0;
    step(20);
    chk("pre_reset_addr", 32'(bus.player_address), 32'h9);
    rst = 1'b0;
    #1;
    chk("midrst_window_open", 32'(bus.window_open), 32'd0);
    chk("midrst_grant", 32'(bus.grant), 32'd0);
    chk("midrst_addr", 32'(bus.player_address), 32'd0);
    chk("midrst_frame_count", 32'(bus.frame_count), 32'd0);
    step(2);
    rst = 1'b1;
    step(2);

    // Request raised outside the window waits for the next vsync fall.
    bus.req = 2'b10; bus.req_addr1 = 4'hA;
    step(20);
    chk("pending_addr", 32'(bus.player_address), 32'd0);
    expect_grant(2'b10, 4'hA);
    vfall();
    step(1);
    chk("pending_granted_addr", 32'(bus.player_address), 32'hA);
    bus.req = 2'b00;
    step(WIN);
    chk("frame_count_after_rst", 32'(bus.frame_count), 32'd1);

    // Both raised on the last window cycle: rr_ptr=0 grants player 1 on the closing edge.
    vfall();
    step(WIN - 1);
    bus.req = 2'b11; bus.req_addr0 = 4'hC; bus.req_addr1 = 4'hD;
    expect_grant(2'b01, 4'hC);
    step(1);
    chk("last_cycle_closed", 32'(bus.window_open), 32'd0);
    chk("last_cycle_addr", 32'(bus.player_address), 32'hC);
`ifdef FRAME_UPDATE_DROP_CNT_EN
    chk("drop_count_one", 32'(bus.drop_count), 32'd1);
`endif
    bus.req = 2'b00;
    step(3);

    // Frame counter wraps after 256 windows.
    for (int i = 0; i < 253; i++) begin
      vfall();
      step(WIN + 2);
    end
    chk("frame_count_255", 32'(bus.frame_count), 32'd255);
    vfall();
    step(WIN + 2);
    chk("frame_count_wrap", 32'(bus.frame_count), 32'd0);
`ifdef FRAME_UPDATE_DROP_CNT_EN
    chk("drop_count_idle", 32'(bus.drop_count), 32'd1);
`endif

    step(3);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    fork
      monitor();
      run();
    join_any
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
